// File: rtl/time_display_mux.sv
// Six-digit multiplexed 7-seg driver; snapshots time once per frame, blinks set-mode pairs, blanks anodes on slot entry.
// Outputs registered 1 cycle after pcnt/idx; no handshake. Optional LEADING_ZERO_BLANK_EN hides a zero hours-tens digit.
module time_display_mux #(
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_DIV  = 8,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] hh_mm_ss,
  input  logic        am_pm,
  input  logic        mode12h,
  input  logic [2:0]  blink_mask,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        dp
);

  localparam logic [15:0] PCNT_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_DIV - 1);

  logic [15:0] pcnt;
  logic [2:0]  idx;
  logic [7:0]  frame_cnt;
  logic        hidden;
  logic        load_first;
  logic [19:0] snap_time;
  logic        snap_pm;
  logic [2:0]  snap_mask;

  logic        slot_end;
  logic        frame_end;
  logic [3:0]  digit;
  logic        pair_blink;
  logic        blank;
  logic [6:0]  seg_c;
  logic [5:0]  an_c;
  logic        dp_c;

  assign slot_end  = (pcnt == PCNT_LAST);
  assign frame_end = slot_end && (idx == 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_cnt  <= '0;
      hidden     <= 1'b0;
      load_first <= 1'b1;
      snap_time  <= '0;
      snap_pm    <= 1'b0;
      snap_mask  <= '0;
    end else begin
      load_first <= 1'b0;
      if (slot_end) begin
        pcnt <= '0;
        idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          hidden    <= ~hidden;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
      // Snapshot only at frame boundaries so one frame never mixes two times.
      if (frame_end || load_first) begin
        snap_time <= hh_mm_ss;
        snap_pm   <= mode12h & am_pm;
        snap_mask <= blink_mask;
      end
    end
  end

  always_comb begin
    digit      = 4'd0;
    pair_blink = 1'b0;
    case (idx)
      3'd0: begin digit = snap_time[3:0];            pair_blink = snap_mask[0]; end
      3'd1: begin digit = {1'b0, snap_time[6:4]};    pair_blink = snap_mask[0]; end
      3'd2: begin digit = snap_time[10:7];           pair_blink = snap_mask[1]; end
      3'd3: begin digit = {1'b0, snap_time[13:11]};  pair_blink = snap_mask[1]; end
      3'd4: begin digit = snap_time[17:14];          pair_blink = snap_mask[2]; end
      3'd5: begin digit = {2'b00, snap_time[19:18]}; pair_blink = snap_mask[2]; end
      default: begin digit = 4'd0; pair_blink = 1'b0; end
    endcase

    blank = hidden & pair_blink;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3'd5 && snap_time[19:18] == 2'd0) blank = 1'b1;
`endif

    case (digit)
      4'd0:    seg_c = 7'h3F;
      4'd1:    seg_c = 7'h06;
      4'd2:    seg_c = 7'h5B;
      4'd3:    seg_c = 7'h4F;
      4'd4:    seg_c = 7'h66;
      4'd5:    seg_c = 7'h6D;
      4'd6:    seg_c = 7'h7D;
      4'd7:    seg_c = 7'h07;
      4'd8:    seg_c = 7'h7F;
      4'd9:    seg_c = 7'h6F;
      default: seg_c = 7'h40;
    endcase

    dp_c = (idx == 3'd2) || (idx == 3'd4) || ((idx == 3'd0) && snap_pm);
    // First cycle of every slot keeps all anodes off to avoid ghosting.
    an_c = (pcnt != 16'd0) ? (6'b000001 << idx) : 6'b000000;

    if (blank) begin
      seg_c = 7'h00;
      an_c  = 6'h00;
      dp_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {7{ACTIVE_LOW}};
      an  <= {6{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      seg <= seg_c ^ {7{ACTIVE_LOW}};
      an  <= an_c ^ {6{ACTIVE_LOW}};
      dp  <= dp_c ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_time_display_mux.sv
// Bench for time_display_mux: random and directed stimulus against a cycle-arithmetic reference model.
module tb_time_display_mux;

  localparam int SCAN  = 4;
  localparam int BLINK = 2;
  localparam int FRAME = 6 * SCAN;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] hh_mm_ss;
  logic        am_pm;
  logic        mode12h;
  logic [2:0]  blink_mask;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  // Model state: n = rising edges seen since reset released; m_* = snapshot in force.
  int          n = 0;
  logic [19:0] m_t;
  logic        m_pm;
  logic [2:0]  m_mk;
  logic [6:0]  exp_seg;
  logic [5:0]  exp_an;
  logic        exp_dp;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] static_seg [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};

  time_display_mux #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .hh_mm_ss(hh_mm_ss), .am_pm(am_pm), .mode12h(mode12h),
    .blink_mask(blink_mask), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Expected outputs for the state reached after j edges, from plain arithmetic on j.
  function automatic void model(input int j, input logic [19:0] t, input logic pm, input logic [2:0] mk,
                                output logic [6:0] s, output logic [5:0] a, output logic d);
    int pc, id, fr;
    int dig [6];
    bit hide;
    pc = j % SCAN;
    id = (j / SCAN) % 6;
    fr = j / FRAME;
    dig[0] = int'(t) & 15;
    dig[1] = (int'(t) >> 4) & 7;
    dig[2] = (int'(t) >> 7) & 15;
    dig[3] = (int'(t) >> 11) & 7;
    dig[4] = (int'(t) >> 14) & 15;
    dig[5] = (int'(t) >> 18) & 3;
    hide = ((fr / BLINK) % 2 == 1) && mk[id / 2];
`ifdef LEADING_ZERO_BLANK_EN
    if (id == 5 && dig[5] == 0) hide = 1'b1;
`endif
    s = hide ? 7'h00 : (dig[id] > 9 ? 7'h40 : seg_tab[dig[id]]);
    a = (hide || pc == 0) ? 6'h00 : 6'(1 << id);
    d = !hide && (id == 2 || id == 4 || (id == 0 && pm));
  endfunction

  task automatic tick();
    logic [19:0] ct;
    logic        cpm, crst;
    logic [2:0]  cmk;
    ct = hh_mm_ss; cpm = mode12h & am_pm; cmk = blink_mask; crst = rst;
    @(posedge clk);
    if (crst) begin
      n = 0; m_t = '0; m_pm = 1'b0; m_mk = '0;
      exp_seg = '0; exp_an = '0; exp_dp = 1'b0;
    end else begin
      model(n, m_t, m_pm, m_mk, exp_seg, exp_an, exp_dp);
      n++;
      if (n == 1 || n % FRAME == 0) begin
        m_t = ct; m_pm = cpm; m_mk = cmk;
      end
    end
    #1;
  endtask

  function automatic int an_index(input logic [5:0] a);
    an_index = -1;
    for (int k = 0; k < 6; k++) if (a == 6'(1 << k)) an_index = k;
  endfunction

  task automatic test_reset();
    int first = -1;
    rst = 1'b1; hh_mm_ss = 20'h49A56; am_pm = 1'b0; mode12h = 1'b0; blink_mask = 3'b000;
    repeat (2) tick();
    checks++;
    if ({seg, an, dp} !== 14'h0) begin
      failures++; $display("FAIL reset_outputs got seg=%h an=%h dp=%b want all 0", seg, an, dp);
    end
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL reset_release c=%0d got %h/%h/%b want %h/%h/%b", c, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      if (an === 6'h01 && first < 0) first = c;
    end
    checks++;
    if (first != 2) begin
      failures++; $display("FAIL first_anode got cycle %0d want 2", first);
    end
  endtask

  task automatic test_static();
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL static n=%0d got %h/%h/%b want %h/%h/%b", n, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      if (an_index(an) >= 0) begin
        checks++;
        if (seg !== static_seg[an_index(an)] || dp !== (an == 6'h04 || an == 6'h10)) begin
          failures++; $display("FAIL static_table an=%h got seg=%h dp=%b want seg=%h", an, seg, dp, static_seg[an_index(an)]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    bit found = 1'b0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      if ((n / SCAN) % 6 == 3 && n % SCAN == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL snapshot_wait got no idx3 slot want one within %0d cycles", 2 * FRAME);
    end
    hh_mm_ss = 20'h00000;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL snapshot n=%0d got %h/%h/%b want %h/%h/%b", n, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      // Outputs for the old frame keep 3,2,1; the following frame shows zeros.
      if (an_index(an) >= 3 && (n - 1) % FRAME >= 3 * SCAN && (n - 1) / FRAME == (n - 2 - c) / FRAME) begin
        checks++;
        if (seg !== static_seg[an_index(an)]) begin
          failures++; $display("FAIL snapshot_old an=%h got seg=%h want %h", an, seg, static_seg[an_index(an)]);
        end
      end
    end
  endtask

  task automatic test_pm();
    hh_mm_ss = 20'h49A56; mode12h = 1'b1; am_pm = 1'b1;
    for (int c = 0; c < 4 * FRAME; c++) begin
      if (c == 2 * FRAME) mode12h = 1'b0;
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL pm n=%0d got %h/%h/%b want %h/%h/%b", n, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
    am_pm = 1'b0;
  endtask

  task automatic test_invalid();
    int seen = 0;
    hh_mm_ss = 20'h49A5B;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 2 * FRAME) hh_mm_ss = {2'd3, 4'hF, 3'd7, 4'hC, 3'd7, 4'hA};
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL invalid n=%0d got %h/%h/%b want %h/%h/%b", n, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      if (an === 6'h01 && c < 2 * FRAME) begin
        seen++;
        checks++;
        if (seg !== 7'h40) begin
          failures++; $display("FAIL invalid_s0 got seg=%h want 40", seg);
        end
      end
    end
    checks++;
    if (seen == 0) begin
      failures++; $display("FAIL invalid_slot got 0 an=01 cycles want >0");
    end
  endtask

  task automatic test_blink();
    int cnt4 [6];
    int cnt8 [6];
    for (int f = 0; f < 6; f++) begin cnt4[f] = 0; cnt8[f] = 0; end
    rst = 1'b1; hh_mm_ss = 20'h49A56; blink_mask = 3'b010; mode12h = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL blink n=%0d got %h/%h/%b want %h/%h/%b", n, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      if (an === 6'h04) cnt4[(n - 1) / FRAME]++;
      if (an === 6'h08) cnt8[(n - 1) / FRAME]++;
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (cnt4[f] != ((f == 2 || f == 3) ? 0 : SCAN - 1) || cnt8[f] != ((f == 2 || f == 3) ? 0 : SCAN - 1)) begin
        failures++;
        $display("FAIL blink_frame f=%0d got an04=%0d an08=%0d want %0d", f, cnt4[f], cnt8[f], (f == 2 || f == 3) ? 0 : SCAN - 1);
      end
    end
    blink_mask = 3'b000;
  endtask

  task automatic test_random();
    for (int c = 0; c < 10 * FRAME; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        hh_mm_ss   = 20'($urandom);
        am_pm      = 1'($urandom);
        mode12h    = 1'($urandom);
        blink_mask = 3'($urandom);
      end
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL random n=%0d got %h/%h/%b want %h/%h/%b", n, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int first = -1;
    hh_mm_ss = 20'h49A56; blink_mask = 3'b000;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      tick();
      if ((n / SCAN) % 6 == 4 && n % SCAN == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_mid_wait got no idx4 slot want one within %0d cycles", 2 * FRAME);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({seg, an, dp} !== 14'h0) begin
      failures++; $display("FAIL reset_mid got seg=%h an=%h dp=%b want all 0", seg, an, dp);
    end
    rst = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      checks++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        failures++; $display("FAIL reset_mid_run c=%0d got %h/%h/%b want %h/%h/%b", c, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
      if (an !== 6'h00 && first < 0) first = c;
    end
    checks++;
    if (first != 2) begin
      failures++; $display("FAIL reset_mid_anode got cycle %0d want 2", first);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_snapshot();
    test_pm();
    test_invalid();
    test_blink();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_display_mux.md
# time_display_mux

Multiplexed six-digit seven-segment display driver for the digital clock: the consumer end of the packed BCD time bus driven by `time_view`. It snapshots `hh_mm_ss`/`am_pm` once per scan frame, so a frame never mixes two different times. It then time-multiplexes the six digits onto one shared segment bus with per-digit anode enables, separator/PM dots, anti-ghosting blanking and field blinking for set mode.

## Interface
- `SCAN_DIV`, default 4: clock cycles per digit slot; legal range 2..65535.
- `BLINK_DIV`, default 8: scan frames per blink half-period; legal range 1..255.
- `ACTIVE_LOW`, default 1: 1 inverts `seg`, `an` and `dp` at the output registers.
- `clk` in 1: system clock. One clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `hh_mm_ss` in 20: packed time in the `time_view` layout: [3:0] s0, [6:4] s1, [10:7] m0, [13:11] m1, [17:14] h0, [19:18] h1.
- `am_pm` in 1: 1 = PM.
- `mode12h` in 1: 12-hour display mode; enables the PM dot.
- `blink_mask` in 3: bit0 = seconds pair, bit1 = minutes pair, bit2 = hours pair.
- `seg` out 7: {g,f,e,d,c,b,a}, registered.
- `an` out 6: digit enables; an[0] = s0 … an[5] = h1; registered.
- `dp` out 1: decimal point, registered.

## Operation
- **Prescaler `pcnt`** counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and advances the digit index `idx`.
- **Digit index `idx`** counts 0..5 and wraps 5→0. Each wrap ends one frame; a frame is 6·SCAN_DIV cycles.
- **Snapshot register** loads `hh_mm_ss`, `am_pm` and `blink_mask` on the cycle `idx` wraps 5→0. It also loads on the first cycle after reset.
- **Digit select:** `idx` selects one nibble from the snapshot. s1 and m1 are zero-extended to 4 bits; h1 is zero-extended from 2 bits.
- **Decode:** 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F for digits 0–9. Any nibble > 9 decodes to 0x40 ('-').
- **Decimal points:**
  - `dp` is lit on idx 2 and idx 4 (the m0 and h0 separators).
  - `dp` is also lit on idx 0 when snapshot `mode12h & am_pm` = 1.
- **Blink phase:**
  - The phase toggles every BLINK_DIV frames and starts "visible".
  - In the "hidden" phase, digits whose pair bit is set in the snapshot `blink_mask` are suppressed: `an` is inactive and `seg`/`dp` are inactive.
- **Anti-ghosting:** while `pcnt` == 0, every `an` bit is inactive. The enable for the current digit is active for `pcnt` 1..SCAN_DIV-1.
- **Active levels:** all polarities above are active-high internally; ACTIVE_LOW inverts them at the output registers.

## Timing
- **Reset values:**
  - internal: `pcnt` = 0, `idx` = 0, snapshot = 0, blink phase = visible, frame counter = 0.
  - outputs: `seg`, `an` and `dp` all inactive (all 1s when ACTIVE_LOW = 1).
- **Latency:** outputs are registered one cycle after the `pcnt`/`idx` state they reflect. The first lit anode appears at cycle 2 after `rst` deasserts (an[0]).
- **Mid-frame input changes** have no visible effect until the next 5→0 wrap. Changes to `mode12h` are sampled into the snapshot by the same rule.
- **Wrap coincident with a blink-period end:** the phase toggle and the snapshot load happen on the same edge. The new frame uses both new values.
- **`rst` mid-frame:** all state returns to reset values on that edge, with no partial frame and no glitch pulse on `an`.
- The block has no handshake; the input is sampled only as above.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined:** when snapshot h1 == 0, digit 5 is suppressed like a blinked digit (`an[5]`, `seg`, `dp` inactive for the whole slot).
- **Not defined:** h1 == 0 shows '0' (0x3F).
- No other behaviour differs.

## Test plan
All scenarios use SCAN_DIV = 4, BLINK_DIV = 2, ACTIVE_LOW = 0.
- **Static time:** hold `hh_mm_ss` = 0x49A56 (12:34:56), `mode12h` = 0 → per frame, `an` one-hot 0x01..0x20 in order with `seg` 0x7D, 0x6D, 0x66, 0x4F, 0x5B, 0x06. `dp` = 1 only in the 0x04 and 0x10 slots. `an` = 0 on the first cycle of each slot.
- **Snapshot integrity:** change the input from 0x49A56 to 0x00000 during slot idx 3 → the remaining slots still show 3, 2, 1. The next frame shows all '0' (h1 slot dark if `LEADING_ZERO_BLANK_EN`).
- **PM dot:** `mode12h` = 1, `am_pm` = 1 → `dp` = 1 in the an = 0x01 slot. With `mode12h` = 0 it stays 0 in that slot.
- **Invalid BCD:** s0 nibble = 0xB → `seg` = 0x40 in the an = 0x01 slot.
- **Blink:** `blink_mask` = 3'b010 → an 0x04 and 0x08 are absent for frames 2–3, present for frames 0–1 and 4–5. Other digits are unaffected.
- **Reset:** assert `rst` for 1 cycle mid-slot idx 4 → next cycle `seg` = `an` = `dp` = 0. an = 0x01 reappears 2 cycles after deassertion.
